// File: rtl/dm_axi_access.sv
// dm_axi_access: MEM-stage data-memory access unit.
// Converts the EX/MEM load/store request into single-beat AXI4 transactions,
// aligns store data / builds strobes, extends load data, and stalls the
// pipeline until the access completes.
// Ports:
//   clk, rst (async active-low)
//   i_store, i_DM_OE, i_funct3, i_ALUout, i_rs2_data : request from EX/MEM
//   mem_stall (combinational), o_load_data, o_load_valid, o_bus_err
//   AR/R/AW/W/B : AXI4 master channels, single beat, 32-bit data
module dm_axi_access #(
   parameter int unsigned ID_W   = 4,
   parameter int unsigned AXI_ID = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_store,
   input  logic            i_DM_OE,
   input  logic [2:0]      i_funct3,
   input  logic [31:0]     i_ALUout,
   input  logic [31:0]     i_rs2_data,
   output logic            mem_stall,
   output logic [31:0]     o_load_data,
   output logic            o_load_valid,
   output logic            o_bus_err,
   output logic [ID_W-1:0] ARID,
   output logic [31:0]     ARADDR,
   output logic [7:0]      ARLEN,
   output logic [2:0]      ARSIZE,
   output logic [1:0]      ARBURST,
   output logic            ARVALID,
   input  logic            ARREADY,
   input  logic [ID_W-1:0] RID,
   input  logic [31:0]     RDATA,
   input  logic [1:0]      RRESP,
   input  logic            RLAST,
   input  logic            RVALID,
   output logic            RREADY,
   output logic [ID_W-1:0] AWID,
   output logic [31:0]     AWADDR,
   output logic [7:0]      AWLEN,
   output logic [2:0]      AWSIZE,
   output logic [1:0]      AWBURST,
   output logic            AWVALID,
   input  logic            AWREADY,
   output logic [31:0]     WDATA,
   output logic [3:0]      WSTRB,
   output logic            WLAST,
   output logic            WVALID,
   input  logic            WREADY,
   input  logic [ID_W-1:0] BID,
   input  logic [1:0]      BRESP,
   input  logic            BVALID,
   output logic            BREADY
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
   } state_e;

   state_e      state_q;
   logic [31:0] addr_q;
   logic [1:0]  off_q;
   logic [2:0]  funct3_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic [31:0] load_data_q;
   logic        load_valid_q, bus_err_q;

   logic [31:0] wdata_d;
   logic [3:0]  wstrb_d;
   logic [31:0] load_ext_c;
   logic [7:0]  rd_byte_c;
   logic [15:0] rd_half_c;

   // IDs, burst and size fields are not checked on the response side
   logic unused_c;
   assign unused_c = ^{RID, BID, RLAST};

   // Store alignment: replicate the low lanes and shift the strobe to the target bytes
   always_comb begin
      wstrb_d = 4'b1111;
      wdata_d = i_rs2_data;
      case (i_funct3)
         3'b000: begin
            wstrb_d = 4'b0001 << i_ALUout[1:0];
            wdata_d = {4{i_rs2_data[7:0]}};
         end
         3'b001: begin
            wstrb_d = 4'b0011 << {i_ALUout[1], 1'b0};
            wdata_d = {2{i_rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction from the latched byte offset and width code
   always_comb begin
      rd_byte_c = RDATA[7:0];
      case (off_q)
         2'd1:    rd_byte_c = RDATA[15:8];
         2'd2:    rd_byte_c = RDATA[23:16];
         2'd3:    rd_byte_c = RDATA[31:24];
         default: rd_byte_c = RDATA[7:0];
      endcase
      rd_half_c  = off_q[1] ? RDATA[31:16] : RDATA[15:0];
      load_ext_c = RDATA;
      case (funct3_q)
         3'b000:  load_ext_c = {{24{rd_byte_c[7]}}, rd_byte_c};
         3'b100:  load_ext_c = {24'd0, rd_byte_c};
         3'b001:  load_ext_c = {{16{rd_half_c[15]}}, rd_half_c};
         3'b101:  load_ext_c = {16'd0, rd_half_c};
         default: load_ext_c = RDATA;
      endcase
   end

   // Access FSM with registered channel handshakes and result pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         off_q        <= '0;
         funct3_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_store) begin
                  addr_q    <= {i_ALUout[31:2], 2'b00};
                  wdata_q   <= wdata_d;
                  wstrb_q   <= wstrb_d;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  state_q   <= S_WR_REQ;
               end else if (i_DM_OE) begin
                  addr_q    <= {i_ALUout[31:2], 2'b00};
                  off_q     <= i_ALUout[1:0];
                  funct3_q  <= i_funct3;
                  arvalid_q <= 1'b1;
                  state_q   <= S_RD_ADDR;
               end
            end
            S_RD_ADDR: begin
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (RVALID) begin
                  rready_q     <= 1'b0;
                  load_data_q  <= load_ext_c;
                  load_valid_q <= 1'b1;
                  bus_err_q    <= (RRESP != 2'b00);
                  state_q      <= S_DONE;
               end
            end
            S_WR_REQ: begin
               // AW and W complete independently; move on once neither is pending
               if (AWREADY) awvalid_q <= 1'b0;
               if (WREADY)  wvalid_q  <= 1'b0;
               if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (BVALID) begin
                  bready_q  <= 1'b0;
                  bus_err_q <= (BRESP != 2'b00);
                  state_q   <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Stall the pipeline from request visibility until the DONE cycle
   assign mem_stall = ((state_q == S_IDLE) && (i_store || i_DM_OE)) ||
                      (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                      (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);

   assign o_load_data  = load_data_q;
   assign o_load_valid = load_valid_q;
   assign o_bus_err    = bus_err_q;

   assign ARID    = ID_W'(AXI_ID);
   assign ARADDR  = addr_q;
   assign ARLEN   = 8'd0;
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign ARVALID = arvalid_q;
   assign RREADY  = rready_q;

   assign AWID    = ID_W'(AXI_ID);
   assign AWADDR  = addr_q;
   assign AWLEN   = 8'd0;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;
   assign AWVALID = awvalid_q;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign WLAST   = 1'b1;
   assign WVALID  = wvalid_q;
   assign BREADY  = bready_q;

endmodule

// File: tb/tb_dm_axi_access.sv
// tb_dm_axi_access: directed scenarios for the MEM-stage AXI access unit.
module tb_dm_axi_access;
   localparam int unsigned ID_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            i_store = 1'b0, i_DM_OE = 1'b0;
   logic [2:0]      i_funct3 = '0;
   logic [31:0]     i_ALUout = '0, i_rs2_data = '0;
   logic            mem_stall, o_load_valid, o_bus_err;
   logic [31:0]     o_load_data;
   logic [ID_W-1:0] ARID, AWID;
   logic [ID_W-1:0] RID = '0, BID = '0;
   logic [31:0]     ARADDR, AWADDR, WDATA;
   logic [7:0]      ARLEN, AWLEN;
   logic [2:0]      ARSIZE, AWSIZE;
   logic [1:0]      ARBURST, AWBURST;
   logic            ARVALID, RREADY, AWVALID, WVALID, BREADY, WLAST;
   logic [3:0]      WSTRB;
   logic            ARREADY = 1'b1, AWREADY = 1'b1, WREADY = 1'b1;
   logic            RVALID = 1'b0, BVALID = 1'b0, RLAST = 1'b1;
   logic [31:0]     RDATA = '0;
   logic [1:0]      RRESP = '0, BRESP = '0;

   int errors = 0;
   int checks = 0;
   int aw_wait = 0;

   dm_axi_access #(.ID_W(ID_W), .AXI_ID(0)) dut (
      .clk(clk), .rst(rst),
      .i_store(i_store), .i_DM_OE(i_DM_OE), .i_funct3(i_funct3),
      .i_ALUout(i_ALUout), .i_rs2_data(i_rs2_data),
      .mem_stall(mem_stall), .o_load_data(o_load_data),
      .o_load_valid(o_load_valid), .o_bus_err(o_bus_err),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
      .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   // Responder: answers one cycle after READY rises; AWREADY withheld for aw_wait AWVALID cycles
   always @(posedge clk) begin
      #2;
      RVALID  = RREADY;
      BVALID  = BREADY;
      AWREADY = (aw_wait == 0);
      if (AWVALID && aw_wait > 0) aw_wait = aw_wait - 1;
   end

   // Present a load at a negedge, follow it to the DONE cycle, then drop it
   task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rd, input logic [1:0] rr,
                          output logic [31:0] data, output int stall,
                          output int vcnt, output int ecnt, output int arcnt,
                          output logic [31:0] araddr);
      RDATA = rd; RRESP = rr;
      data = '0; stall = 0; vcnt = 0; ecnt = 0; arcnt = 0; araddr = '0;
      i_store = 1'b0; i_DM_OE = 1'b1; i_funct3 = f3; i_ALUout = addr;
      #1;
      for (int c = 0; c < 12; c++) begin
         if (mem_stall) stall++;
         if (o_load_valid) begin vcnt++; data = o_load_data; end
         if (o_bus_err) ecnt++;
         if (ARVALID) begin arcnt++; araddr = ARADDR; end
         if (!mem_stall) break;
         @(negedge clk);
      end
      i_DM_OE = 1'b0;
      @(negedge clk);
      if (o_load_valid) vcnt++;
      if (o_bus_err) ecnt++;
      if (ARVALID) arcnt++;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rs2, input logic oe,
                           input int aw_delay, input logic [1:0] br,
                           output int stall, output int bhs, output int awcnt,
                           output int wcnt, output int arcnt, output int ecnt,
                           output logic [31:0] awaddr, output logic [3:0] wstrb,
                           output logic [31:0] wdata);
      aw_wait = aw_delay; BRESP = br;
      stall = 0; bhs = 0; awcnt = 0; wcnt = 0; arcnt = 0; ecnt = 0;
      awaddr = '0; wstrb = '0; wdata = '0;
      i_store = 1'b1; i_DM_OE = oe; i_funct3 = f3; i_ALUout = addr; i_rs2_data = rs2;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (mem_stall) stall++;
         if (AWVALID) begin awcnt++; awaddr = AWADDR; end
         if (WVALID) begin wcnt++; wstrb = WSTRB; wdata = WDATA; end
         if (BREADY && BVALID) bhs++;
         if (ARVALID) arcnt++;
         if (o_bus_err) ecnt++;
         if (!mem_stall) break;
         @(negedge clk);
      end
      i_store = 1'b0; i_DM_OE = 1'b0;
      @(negedge clk);
      if (AWVALID) awcnt++;
      if (WVALID) wcnt++;
      if (ARVALID) arcnt++;
      if (o_bus_err) ecnt++;
      BRESP = 2'b00;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%b exp=0", ARVALID); end
      checks++; if (RREADY !== 1'b0) begin errors++; $display("FAIL rst_rready got=%b exp=0", RREADY); end
      checks++; if (AWVALID !== 1'b0 || WVALID !== 1'b0) begin errors++; $display("FAIL rst_aw_w got=%b%b exp=00", AWVALID, WVALID); end
      checks++; if (BREADY !== 1'b0) begin errors++; $display("FAIL rst_bready got=%b exp=0", BREADY); end
      checks++; if (o_load_data !== 32'h0) begin errors++; $display("FAIL rst_load_data got=%h exp=0", o_load_data); end
      checks++; if (o_load_valid !== 1'b0 || o_bus_err !== 1'b0) begin errors++; $display("FAIL rst_pulses got=%b%b exp=00", o_load_valid, o_bus_err); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", mem_stall); end
      checks++; if (ARADDR !== 32'h0) begin errors++; $display("FAIL rst_araddr got=%h exp=0", ARADDR); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lw();
      logic [31:0] d, aa; int st, v, e, ar;
      do_load(32'h100, 3'b010, 32'hDEADBEEF, 2'b00, d, st, v, e, ar, aa);
      checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", d); end
      checks++; if (st !== 3) begin errors++; $display("FAIL lw_stall got=%0d exp=3", st); end
      checks++; if (v !== 1 || e !== 0) begin errors++; $display("FAIL lw_pulses got=v%0d e%0d exp=v1 e0", v, e); end
      checks++; if (ar !== 1 || aa !== 32'h100) begin errors++; $display("FAIL lw_ar got=%0d@%h exp=1@00000100", ar, aa); end
   endtask

   task automatic test_load_extend();
      logic [31:0] d, aa; int st, v, e, ar;
      do_load(32'h103, 3'b000, 32'h80FF0000, 2'b00, d, st, v, e, ar, aa);
      checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", d); end
      checks++; if (aa !== 32'h100) begin errors++; $display("FAIL lb_araddr got=%h exp=00000100", aa); end
      do_load(32'h103, 3'b100, 32'h80FF0000, 2'b00, d, st, v, e, ar, aa);
      checks++; if (d !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", d); end
      do_load(32'h102, 3'b101, 32'h80FF0000, 2'b00, d, st, v, e, ar, aa);
      checks++; if (d !== 32'h000080FF) begin errors++; $display("FAIL lhu_data got=%h exp=000080ff", d); end
      do_load(32'h102, 3'b001, 32'h80FF0000, 2'b00, d, st, v, e, ar, aa);
      checks++; if (d !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_data got=%h exp=ffff80ff", d); end
      do_load(32'h101, 3'b000, 32'h80FF0000, 2'b00, d, st, v, e, ar, aa);
      checks++; if (d !== 32'h00000000) begin errors++; $display("FAIL lb1_data got=%h exp=00000000", d); end
   endtask

   task automatic test_store_align();
      logic [31:0] aw, wd; logic [3:0] ws; int st, b, awc, wc, ar, e;
      do_store(32'h206, 3'b001, 32'h1234ABCD, 1'b0, 0, 2'b00, st, b, awc, wc, ar, e, aw, ws, wd);
      checks++; if (aw !== 32'h204) begin errors++; $display("FAIL sh_awaddr got=%h exp=00000204", aw); end
      checks++; if (ws !== 4'b1100 || wd !== 32'hABCDABCD) begin errors++; $display("FAIL sh_w got=%b/%h exp=1100/abcdabcd", ws, wd); end
      checks++; if (b !== 1 || st !== 3) begin errors++; $display("FAIL sh_b got=b%0d st%0d exp=b1 st3", b, st); end
      do_store(32'h201, 3'b000, 32'h0000005A, 1'b0, 0, 2'b00, st, b, awc, wc, ar, e, aw, ws, wd);
      checks++; if (ws !== 4'b0010 || wd !== 32'h5A5A5A5A || aw !== 32'h200) begin errors++; $display("FAIL sb_w got=%b/%h@%h exp=0010/5a5a5a5a@00000200", ws, wd, aw); end
      do_store(32'h20B, 3'b010, 32'hCAFEF00D, 1'b0, 0, 2'b00, st, b, awc, wc, ar, e, aw, ws, wd);
      checks++; if (ws !== 4'b1111 || wd !== 32'hCAFEF00D || aw !== 32'h208) begin errors++; $display("FAIL sw_w got=%b/%h@%h exp=1111/cafef00d@00000208", ws, wd, aw); end
      checks++; if (o_load_data !== 32'h00000000) begin errors++; $display("FAIL load_hold got=%h exp=00000000", o_load_data); end
   endtask

   task automatic test_store_priority();
      logic [31:0] aw, wd; logic [3:0] ws; int st, b, awc, wc, ar, e;
      do_store(32'h300, 3'b010, 32'h11111111, 1'b1, 0, 2'b00, st, b, awc, wc, ar, e, aw, ws, wd);
      checks++; if (ar !== 0 || awc !== 1) begin errors++; $display("FAIL prio got=ar%0d aw%0d exp=ar0 aw1", ar, awc); end
   endtask

   task automatic test_aw_delay();
      logic [31:0] aw, wd; logic [3:0] ws; int st, b, awc, wc, ar, e;
      do_store(32'h400, 3'b010, 32'h76543210, 1'b0, 4, 2'b00, st, b, awc, wc, ar, e, aw, ws, wd);
      checks++; if (wc !== 1) begin errors++; $display("FAIL awd_wvalid got=%0d exp=1", wc); end
      checks++; if (awc !== 5) begin errors++; $display("FAIL awd_awvalid got=%0d exp=5", awc); end
      checks++; if (b !== 1 || st !== 7) begin errors++; $display("FAIL awd_b got=b%0d st%0d exp=b1 st7", b, st); end
   endtask

   task automatic test_bus_err();
      logic [31:0] d, aa, aw, wd; logic [3:0] ws; int st, v, e, ar, b, awc, wc;
      do_load(32'h100, 3'b010, 32'h0BADF00D, 2'b10, d, st, v, e, ar, aa);
      checks++; if (e !== 1 || v !== 1) begin errors++; $display("FAIL rerr_pulses got=e%0d v%0d exp=e1 v1", e, v); end
      checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL rerr_data got=%h exp=0badf00d", d); end
      checks++; if (mem_stall !== 1'b0 || ARVALID !== 1'b0 || RREADY !== 1'b0) begin errors++; $display("FAIL rerr_idle got=%b%b%b exp=000", mem_stall, ARVALID, RREADY); end
      do_store(32'h500, 3'b010, 32'h0, 1'b0, 0, 2'b11, st, b, awc, wc, ar, e, aw, ws, wd);
      checks++; if (e !== 1 || b !== 1) begin errors++; $display("FAIL berr got=e%0d b%0d exp=e1 b1", e, b); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d, aa; int st, v, e, ar;
      RDATA = 32'h55555555; RRESP = 2'b00;
      i_DM_OE = 1'b1; i_funct3 = 3'b010; i_ALUout = 32'h300;
      @(negedge clk);
      @(negedge clk);
      checks++; if (RREADY !== 1'b1) begin errors++; $display("FAIL rmid_in_rd got=%b exp=1", RREADY); end
      rst = 1'b0; i_DM_OE = 1'b0;
      #1;
      checks++; if (RREADY !== 1'b0 || ARVALID !== 1'b0) begin errors++; $display("FAIL rmid_hs got=%b%b exp=00", RREADY, ARVALID); end
      checks++; if (o_load_data !== 32'h0 || o_load_valid !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rmid_out got=%h %b %b exp=0 0 0", o_load_data, o_load_valid, mem_stall); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_load(32'h300, 3'b010, 32'h11223344, 2'b00, d, st, v, e, ar, aa);
      checks++; if (ar !== 1 || aa !== 32'h300) begin errors++; $display("FAIL rmid_fresh_ar got=%0d@%h exp=1@00000300", ar, aa); end
      checks++; if (d !== 32'h11223344 || st !== 3) begin errors++; $display("FAIL rmid_load got=%h st%0d exp=11223344 st3", d, st); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_extend();
      test_store_align();
      test_store_priority();
      test_aw_delay();
      test_bus_err();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
